// File: rtl/wb_sched.sv
// wb_sched: writeback scheduler for the RV32I register-file write path.
// Classifies one decoded instruction at a time, drives the rd write-data mux
// select (00 PC_next, 01 immediate, 10 ALU_res, 11 mem_read), sequences loads
// through a memory-read handshake and counts retired instructions.
// Optional load timeout: define WB_TIMEOUT_EN to enable the LD_WAIT watchdog
// (limit set by MEM_TIMEOUT, legal range 1..255).
module wb_sched #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  input  logic        mem_valid,
  output logic [1:0]  rd_sel,
  output logic [4:0]  rd_addr,
  output logic        reg_we,
  output logic        wb_done,
  output logic        illegal,
  output logic        load_fault,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {IDLE, WB, LD_WAIT} state_t;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;
  localparam logic [1:0] SEL_MEM = 2'b11;

  // Reject an out-of-range timeout limit at elaboration.
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_sched: MEM_TIMEOUT must be in 1..255");
  end

  state_t     state, state_nxt;
  logic [1:0] dec_sel;
  logic       dec_wr, dec_ill, dec_load;
  logic       cls_wr, cls_ill;
  logic       accept, timeout_hit;
  logic       done_int, we_int, ill_int, fault_int;

  // Opcode classification into mux select, write flag, illegal and load.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dec_sel  = SEL_ALU;
    dec_wr   = 1'b0;
    dec_ill  = 1'b0;
    dec_load = 1'b0;
    case (opcode)
      7'b0110111:             begin dec_sel = SEL_IMM; dec_wr = 1'b1; end
      7'b0010111:             begin dec_sel = SEL_ALU; dec_wr = 1'b1; end
      7'b1101111, 7'b1100111: begin dec_sel = SEL_PC;  dec_wr = 1'b1; end
      7'b0110011, 7'b0010011: begin dec_sel = SEL_ALU; dec_wr = 1'b1; end
      7'b0000011:             begin dec_sel = SEL_MEM; dec_wr = 1'b1; dec_load = 1'b1; end
      7'b0100011, 7'b1100011,
      7'b0001111, 7'b1110011: dec_sel = SEL_ALU;
      default:                dec_ill = 1'b1;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  logic [7:0] to_cnt;

  assign timeout_hit = !mem_valid && (to_cnt == 8'(MEM_TIMEOUT));

  // Watchdog: cleared on entry to LD_WAIT, counts cycles without mem_valid.
  always_ff @(posedge clk) begin
    if (rst)                              to_cnt <= '0;
    else if (accept)                      to_cnt <= '0;
    else if (state == LD_WAIT && !mem_valid) to_cnt <= to_cnt + 8'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    accept      = 1'b0;
    done_int    = 1'b0;
    we_int      = 1'b0;
    ill_int     = 1'b0;
    fault_int   = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept    = 1'b1;
          state_nxt = dec_load ? LD_WAIT : WB;
        end
      end
      WB: begin
        done_int  = 1'b1;
        we_int    = cls_wr && (rd_addr != 5'd0);
        ill_int   = cls_ill;
        state_nxt = IDLE;
      end
      LD_WAIT: begin
        mem_req = 1'b1;
        if (mem_valid) begin
          done_int  = 1'b1;
          we_int    = (rd_addr != 5'd0);
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          done_int  = 1'b1;
          fault_int = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are suppressed while reset is being sampled.
  assign reg_we     = we_int    && !rst;
  assign wb_done    = done_int  && !rst;
  assign illegal    = ill_int   && !rst;
  assign load_fault = fault_int && !rst;

  // State, latched instruction class and retire counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state      <= IDLE;
      rd_sel     <= SEL_ALU;
      rd_addr    <= 5'd0;
      cls_wr     <= 1'b0;
      cls_ill    <= 1'b0;
      retire_cnt <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rd_sel  <= dec_sel;
        rd_addr <= rd_in;
        cls_wr  <= dec_wr;
        cls_ill <= dec_ill;
      end
      if (done_int) retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_sched.sv
// Self-checking bench for wb_sched: directed scenarios plus randomized
// instruction stream, scoreboard queue filled at accept, popped by a monitor.
module tb_wb_sched;

  logic        clk = 1'b0;
  logic        rst, instr_valid, mem_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd_in;
  logic        instr_ready, mem_req, reg_we, wb_done, illegal, load_fault;
  logic [1:0]  rd_sel;
  logic [4:0]  rd_addr;
  logic [31:0] retire_cnt;

  always #5 clk = ~clk;

  wb_sched #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd_in(rd_in), .mem_req(mem_req), .mem_valid(mem_valid),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .reg_we(reg_we), .wb_done(wb_done),
    .illegal(illegal), .load_fault(load_fault), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic        we;
    logic        ill;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned issued = 0;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_OP = 7'b0110011, OP_IMM = 7'b0010011,
                         OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BR = 7'b1100011,
                         OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference classification straight from the opcode table.
  function automatic void classify(input logic [6:0] op, output logic [1:0] sel,
                                   output logic wr, output logic ill, output logic ld);
    sel = 2'b10; wr = 1'b0; ill = 1'b0; ld = 1'b0;
    if (op == OP_LUI) begin sel = 2'b01; wr = 1'b1; end
    else if (op == OP_JAL || op == OP_JALR) begin sel = 2'b00; wr = 1'b1; end
    else if (op == OP_AUIPC || op == OP_OP || op == OP_IMM) wr = 1'b1;
    else if (op == OP_LOAD) begin sel = 2'b11; wr = 1'b1; ld = 1'b1; end
    else if (!(op == OP_STORE || op == OP_BR || op == OP_FENCE || op == OP_SYS)) ill = 1'b1;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports a completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (!wb_done && (reg_we || illegal || load_fault))
        check("strobe_without_done", {29'd0, reg_we, illegal, load_fault}, 32'd0);
      if (mem_req) check("ready_during_load", instr_ready, 1'b0);
      if (wb_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", wb_done, 1'b0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rd_sel", rd_sel, e.sel);
          check("rd_addr", rd_addr, e.addr);
          check("reg_we", reg_we, e.we);
          check("illegal", illegal, e.ill);
          check("load_fault", load_fault, e.fault);
          check("retire_cnt", retire_cnt, e.cnt);
        end
      end
    end
  end

  // Present an instruction and return #1 after the edge that accepts it.
  task automatic accept_instr(input logic [6:0] op, input logic [4:0] rd);
    int n = 0;
    opcode = op; rd_in = rd; instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("accept_wait", instr_ready, 1'b1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    opcode = 7'($urandom); rd_in = 5'($urandom);
  endtask

  function automatic exp_t make_exp(input logic [6:0] op, input logic [4:0] rd);
    exp_t e; logic [1:0] s; logic wr, ill, ld;
    classify(op, s, wr, ill, ld);
    e.sel = s; e.addr = rd; e.we = wr && (rd != 5'd0); e.ill = ill; e.fault = 1'b0;
    e.cnt = issued;
    return e;
  endfunction

  // Full instruction: loads see wait_lo cycles of mem_valid low, then one high.
  task automatic issue(input logic [6:0] op, input logic [4:0] rd, input int wait_lo);
    exp_t e;
    e = make_exp(op, rd);
    accept_instr(op, rd);
    sb_q.push_back(e);
    issued++;
    if (op != OP_LOAD) begin
      @(negedge clk);
      check("wb_latency", wb_done, 1'b1);
    end else begin
      for (int i = 0; i <= wait_lo; i++) begin
        instr_valid = (i < wait_lo);     // ignored while busy
        mem_valid   = (i == wait_lo);
        @(negedge clk);
        check("mem_req_held", mem_req, 1'b1);
        check("load_done_cycle", wb_done, (i == wait_lo));
        @(posedge clk); #1;
      end
      mem_valid = 1'b0; instr_valid = 1'b0;
      @(negedge clk);
      check("mem_req_fall", mem_req, 1'b0);
    end
  endtask

  task automatic stuck_load(input logic [4:0] rd);
    exp_t e;
    e = make_exp(OP_LOAD, rd);
    accept_instr(OP_LOAD, rd);
    issued++;
`ifdef WB_TIMEOUT_EN
    e.we = 1'b0; e.fault = 1'b1;
    sb_q.push_back(e);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("to_mem_req", mem_req, 1'b1);
      check("to_fault_cycle", load_fault, (c == 5));
    end
    @(negedge clk);
    check("to_idle", instr_ready, 1'b1);
`else
    begin
      int lows = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (mem_req !== 1'b1 || wb_done !== 1'b0) lows++;
      end
      check("mem_req_100_cycles", lows, 0);
    end
    sb_q.push_back(e);
    @(posedge clk); #1 mem_valid = 1'b1;
    @(posedge clk); #1 mem_valid = 1'b0;
    @(negedge clk);
    check("stuck_release", mem_req, 1'b0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[11];
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_IMM, OP_LOAD,
            OP_STORE, OP_BR, OP_FENCE, OP_SYS};
    rst = 1'b1; instr_valid = 1'b0; mem_valid = 1'b0; opcode = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_rd_sel", rd_sel, 2'b10);
    check("rst_rd_addr", rd_addr, 5'd0);
    check("rst_strobes", {reg_we, wb_done, illegal, load_fault}, 4'd0);
    check("rst_retire", retire_cnt, 32'd0);

    issue(OP_IMM, 5'd5, 0);
    @(posedge clk); #1;
    check("retire_after_addi", retire_cnt, 32'd1);
    issue(OP_LUI, 5'd0, 0);
    issue(OP_LOAD, 5'd7, 3);
    issue(OP_JAL, 5'd1, 0);
    issue(7'b1111111, 5'd9, 0);

    // Reset while a load is outstanding.
    accept_instr(OP_LOAD, 5'd12);
    @(negedge clk);
    check("pre_rst_mem_req", mem_req, 1'b1);
    @(posedge clk); #1 rst = 1'b1; mem_valid = 1'b1;
    @(negedge clk);
    check("rst_cycle_strobes", {reg_we, wb_done}, 2'd0);
    @(posedge clk); #1 rst = 1'b0;
    sb_q.delete(); issued = 0;
    @(negedge clk);
    check("post_rst_mem_req", mem_req, 1'b0);
    check("post_rst_ready", instr_ready, 1'b1);
    check("post_rst_rd_sel", rd_sel, 2'b10);
    check("post_rst_rd_addr", rd_addr, 5'd0);
    check("post_rst_retire", retire_cnt, 32'd0);
    check("late_mem_valid", {reg_we, wb_done}, 2'd0);
    @(posedge clk); #1 mem_valid = 1'b0;

    issue(OP_OP, 5'd3, 0);
    stuck_load(5'd14);

    for (int k = 0; k < 60; k++) begin
      logic [6:0] op;
      logic [4:0] rd;
      op = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      issue(op, rd, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("final_retire", retire_cnt, issued);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
